// File: rtl/fir_out_conditioner.sv
// Output conditioner for the FIR filter: warm-up discard, round/saturate to the output width,
// decimate, and buffer in a first-word-fall-through FIFO with a valid/ready output.
module fir_out_conditioner #(
  parameter int unsigned DATA_IN_WIDTH   = 32,
  parameter int unsigned DATA_OUT_WIDTH  = 16,
  parameter int unsigned SHIFT           = 12,
  parameter int unsigned DECIM           = 4,
  parameter int unsigned WARMUP          = 53,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned FIFO_ADDR_WIDTH = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_fir_en,
  input  logic signed [DATA_IN_WIDTH-1:0]  i_fir_data,
  input  logic                             i_ready,
  output logic signed [DATA_OUT_WIDTH-1:0] o_data,
  output logic                             o_valid,
  output logic [FIFO_ADDR_WIDTH:0]         o_fifo_count,
  output logic                             o_overflow,
  output logic                             o_sat
);

  localparam int unsigned ExtW   = DATA_IN_WIDTH + 1;
  localparam int unsigned WarmW  = $clog2(WARMUP + 1);
  localparam int unsigned PhaseW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic signed [ExtW-1:0] RoundBias = ExtW'(64'd1 << (SHIFT - 1));
  localparam logic signed [ExtW-1:0] SatMax    = ExtW'((64'd1 << (DATA_OUT_WIDTH - 1)) - 64'd1);
  localparam logic signed [ExtW-1:0] SatMin    = ~SatMax;

  typedef enum logic {StWarmup, StRun} state_e;

  state_e                             state_q, state_d;
  logic [WarmW-1:0]                   warm_cnt_q, warm_cnt_d;
  logic                               s1_valid_q, s1_valid_d;
  logic signed [DATA_OUT_WIDTH-1:0]   s1_data_q, s1_data_d;
  logic [PhaseW-1:0]                  phase_q, phase_d;
  logic [FIFO_ADDR_WIDTH-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_ADDR_WIDTH:0]           count_q, count_d;
  logic                               sat_q, sat_d, ovf_q, ovf_d;
  logic signed [DATA_OUT_WIDTH-1:0]   mem_q [FIFO_DEPTH];

  logic signed [ExtW-1:0]             x_ext, sum, shifted;
  logic signed [DATA_OUT_WIDTH-1:0]   sat_val;
  logic                               clip_hi, clip_lo, run_accept, keep, push, pop, full;

  // Round half toward +inf, then clamp to the signed output range.
  always_comb begin
    x_ext   = {i_fir_data[DATA_IN_WIDTH-1], i_fir_data};
    sum     = x_ext + RoundBias;
    shifted = sum >>> SHIFT;
    clip_hi = shifted > SatMax;
    clip_lo = shifted < SatMin;
    if (clip_hi) begin
      sat_val = SatMax[DATA_OUT_WIDTH-1:0];
    end else if (clip_lo) begin
      sat_val = SatMin[DATA_OUT_WIDTH-1:0];
    end else begin
      sat_val = shifted[DATA_OUT_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    if (state_q == StWarmup && i_fir_en) begin
      if (warm_cnt_q == WarmW'(WARMUP - 1)) begin
        state_d = StRun;
      end else begin
        warm_cnt_d = warm_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    run_accept = (state_q == StRun) && i_fir_en;
    s1_valid_d = run_accept;
    s1_data_d  = run_accept ? sat_val : s1_data_q;
    sat_d      = sat_q | (run_accept & (clip_hi | clip_lo));

    phase_d = phase_q;
    if (s1_valid_q) begin
      phase_d = (phase_q == PhaseW'(DECIM - 1)) ? '0 : phase_q + 1'b1;
    end
    keep = s1_valid_q && (phase_q == '0);

    pop   = o_valid && i_ready;
    full  = count_q == (FIFO_ADDR_WIDTH + 1)'(FIFO_DEPTH);
    push  = keep && (!full || pop);
    ovf_d = ovf_q | (keep & ~push);

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StWarmup;
      warm_cnt_q <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      phase_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sat_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      phase_q    <= phase_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sat_q      <= sat_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only observable between push and pop.
  always_ff @(posedge i_clk) begin
    if (!i_rst && push) begin
      mem_q[wr_ptr_q] <= s1_data_q;
    end
  end

  always_comb begin
    o_valid      = count_q != '0;
    o_data       = o_valid ? mem_q[rd_ptr_q] : '0;
    o_fifo_count = count_q;
    o_overflow   = ovf_q;
    o_sat        = sat_q;
  end

endmodule

// File: tb/tb_fir_out_conditioner.sv
// Scoreboard bench for fir_out_conditioner (DECIM=4): directed stimulus pushes expected outputs,
// a negedge monitor compares every presented head / popped word against the queue.
module tb_fir_out_conditioner;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               fir_en = 1'b0;
  logic signed [31:0] fir_data = '0;
  logic               ready = 1'b1;
  logic signed [15:0] o_data;
  logic               o_valid;
  logic [4:0]         o_fifo_count;
  logic               o_overflow;
  logic               o_sat;

  int n_cmp = 0;
  int n_bad = 0;
  logic signed [15:0] exp_q[$];

  fir_out_conditioner dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_fir_en    (fir_en),
    .i_fir_data  (fir_data),
    .i_ready     (ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_fifo_count(o_fifo_count),
    .o_overflow  (o_overflow),
    .o_sat       (o_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Monitor: head must match the queue head; a pop consumes it.
  always @(negedge clk) begin
    if (!rst && o_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %0d, want no output", o_data);
      end else if (ready) begin
        check("pop_data", int'(o_data), int'(exp_q.pop_front()));
      end else begin
        check("stalled_head", int'(o_data), int'(exp_q[0]));
      end
    end
  end

  task automatic strobe(input logic signed [31:0] x);
    fir_en   = 1'b1;
    fir_data = x;
    @(posedge clk);
    #1;
    fir_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One decimation frame: the kept sample followed by three dropped zeros.
  task automatic frame(input logic signed [31:0] x, input logic signed [15:0] e, input bit exp_push);
    if (exp_push) exp_q.push_back(e);
    strobe(x);
    for (int i = 0; i < 3; i++) strobe(32'sd0);
  endtask

  task automatic wait_empty();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || o_valid) && cyc < 200) begin
      idle(1);
      cyc++;
    end
    check("drain_timeout", int'(exp_q.size() != 0 || o_valid), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic signed [31:0] rnd_x [5];
    logic signed [15:0] rnd_e [5];
    rnd_x = '{32'sd2047, 32'sd2048, -32'sd2048, -32'sd2049, 32'sd4095};
    rnd_e = '{16'sd0, 16'sd1, 16'sd0, -16'sd1, 16'sd1};

    idle(2);
    rst = 1'b0;
    check("rst_valid", int'(o_valid), 0);
    check("rst_count", int'(o_fifo_count), 0);
    check("rst_overflow", int'(o_overflow), 0);
    check("rst_sat", int'(o_sat), 0);
    check("rst_data", int'(o_data), 0);

    // Warm-up: 53 discarded, 54th is kept.
    for (int i = 0; i < 53; i++) strobe(32'sd8192);
    idle(2);
    check("warmup_count", int'(o_fifo_count), 0);
    ready = 1'b0;
    exp_q.push_back(16'sd2);
    strobe(32'sd8192);
    check("latency_valid_e", int'(o_valid), 0);
    idle(1);
    check("first_count", int'(o_fifo_count), 1);
    check("first_data", int'(o_data), 2);
    ready = 1'b1;
    for (int i = 0; i < 3; i++) strobe(32'sd0);
    wait_empty();

    // Rounding: each value is the kept sample of its frame.
    for (int i = 0; i < 5; i++) frame(rnd_x[i], rnd_e[i], 1'b1);
    wait_empty();
    check("round_no_sat", int'(o_sat), 0);

    // Decimation: back-to-back ramp, then with 3-cycle gaps.
    for (int k = 0; k < 12; k++) begin
      if (k % 4 == 0) exp_q.push_back(16'(k));
      strobe(k * 4096);
    end
    wait_empty();
    for (int k = 0; k < 12; k++) begin
      if (k % 4 == 0) exp_q.push_back(16'(k));
      strobe(k * 4096);
      idle(3);
    end
    wait_empty();

    // Saturation.
    check("sat_before", int'(o_sat), 0);
    exp_q.push_back(16'sd32767);
    strobe(32'h7FFF_FFFF);
    check("sat_after_edge", int'(o_sat), 1);
    for (int i = 0; i < 3; i++) strobe(32'sd0);
    frame(32'h8000_0000, -16'sd32768, 1'b1);
    wait_empty();
    check("sat_sticky", int'(o_sat), 1);

    // Full / overflow.
    ready = 1'b0;
    for (int n = 1; n <= 16; n++) frame(n * 4096, 16'(n), 1'b1);
    check("full_count", int'(o_fifo_count), 16);
    check("full_no_ovf", int'(o_overflow), 0);
    frame(17 * 4096, 16'sd17, 1'b0);
    check("ovf_count", int'(o_fifo_count), 16);
    check("ovf_set", int'(o_overflow), 1);
    exp_q.push_back(16'sd18);
    strobe(18 * 4096);
    ready = 1'b1;
    idle(1);
    ready = 1'b0;
    check("pushpop_count", int'(o_fifo_count), 16);
    check("pushpop_ovf", int'(o_overflow), 1);
    for (int i = 0; i < 3; i++) strobe(32'sd0);
    for (int i = 0; i < 120 && exp_q.size() != 0; i++) begin
      ready = (i % 3) != 0;
      idle(1);
    end
    ready = 1'b1;
    wait_empty();

    // Reset mid-stream.
    ready = 1'b0;
    for (int n = 1; n <= 5; n++) frame(n * 4096, 16'(n), 1'b1);
    check("pre_rst_count", int'(o_fifo_count), 5);
    strobe(6 * 4096);
    rst = 1'b1;
    exp_q.delete();
    idle(1);
    rst = 1'b0;
    check("mid_rst_valid", int'(o_valid), 0);
    check("mid_rst_count", int'(o_fifo_count), 0);
    check("mid_rst_ovf", int'(o_overflow), 0);
    check("mid_rst_sat", int'(o_sat), 0);
    check("mid_rst_data", int'(o_data), 0);
    ready = 1'b1;
    for (int i = 0; i < 53; i++) strobe(32'sd8192);
    idle(3);
    check("rewarm_count", int'(o_fifo_count), 0);
    exp_q.push_back(16'sd2);
    strobe(32'sd8192);
    wait_empty();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
